// File: rtl/ccgrcg_pipe_if.sv
// rtl/ccgrcg_pipe_if.sv - vector in / result out valid-ready handshake bundle
interface ccgrcg_pipe_if #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 30
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  x;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] f;

  modport master (
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  f
  );

  modport slave (
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output f
  );
endinterface

// File: rtl/ccgrcg_pipe.sv
// rtl/ccgrcg_pipe.sv - pipelined CCGRCG function core with MISR output compaction
module ccgrcg_pipe #(
  parameter int               N_IN   = 10,
  parameter int               N_OUT  = 30,
  parameter int               STAGES = 2,
  parameter logic [N_OUT-1:0] MAP    = 30'h2AAAAAAA,
  parameter int               MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY  = 16'h1021
) (
  input  logic              clk,
  input  logic              rst,
  ccgrcg_pipe_if.slave      bus,
  input  logic              sig_clear,
  output logic [MISR_W-1:0] sig,
  output logic [15:0]       count
);

  localparam int CHUNKS = (N_OUT + MISR_W - 1) / MISR_W;
  localparam int PAD_W  = CHUNKS * MISR_W;

  logic                          fa;
  logic                          fb;
  logic [N_OUT-1:0]              r;
  logic [STAGES-1:0]             vld;
  logic [STAGES-1:0][N_OUT-1:0]  data;
  logic                          stall;
  logic                          out_xfer;
  logic [PAD_W-1:0]              f_pad;
  logic [MISR_W-1:0]             fold;
  logic [MISR_W-1:0]             sig_next;

  always_comb begin
    fa = bus.x[0] & bus.x[4];
    fb = bus.x[3] ^ bus.x[4] ^ (bus.x[1] & bus.x[N_IN-2])
       ^ (bus.x[2] & bus.x[3] & bus.x[N_IN-1]);
    r  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      r[k] = MAP[k] ? fb : fa;
    end
  end

  // Global stall: the whole pipe freezes while the last stage is blocked.
  assign stall        = vld[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.f        = data[STAGES-1];
  assign out_xfer     = vld[STAGES-1] & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= '0;
      data <= '0;
    end else if (!stall) begin
      vld[0]  <= bus.in_valid;
      data[0] <= r;
      for (int i = 1; i < STAGES; i++) begin
        vld[i]  <= vld[i-1];
        data[i] <= data[i-1];
      end
    end
  end

  assign f_pad = PAD_W'(data[STAGES-1]);

  always_comb begin
    fold = '0;
    for (int c = 0; c < CHUNKS; c++) begin
      fold = fold ^ f_pad[c*MISR_W +: MISR_W];
    end
    sig_next = {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? POLY : '0) ^ fold;
  end

  // Clear wins over a same-cycle transfer; that transfer is simply not folded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig   <= '0;
      count <= '0;
    end else if (sig_clear) begin
      sig   <= '0;
      count <= '0;
    end else if (out_xfer) begin
      sig <= sig_next;
      if (count != 16'hFFFF) begin
        count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ccgrcg_pipe.sv
// tb/tb_ccgrcg_pipe.sv - self-checking bench for ccgrcg_pipe, default and small configs
module tb_ccgrcg_pipe;

  bit clk;
  bit rst = 1'b1;
  logic clr0, clr1;
  logic [15:0] sig0;
  logic [3:0]  sig1;
  logic [15:0] cnt0, cnt1;

  int n_err = 0;
  int n_chk = 0;

  ccgrcg_pipe_if #(.N_IN(10), .N_OUT(30)) in0 ();
  ccgrcg_pipe_if #(.N_IN(6),  .N_OUT(5))  in1 ();

  ccgrcg_pipe u0 (
    .clk(clk), .rst(rst), .bus(in0), .sig_clear(clr0), .sig(sig0), .count(cnt0)
  );

  ccgrcg_pipe #(
    .N_IN(6), .N_OUT(5), .STAGES(1), .MAP(5'b10101), .MISR_W(4), .POLY(4'h3)
  ) u1 (
    .clk(clk), .rst(rst), .bus(in1), .sig_clear(clr1), .sig(sig1), .count(cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: functions straight from the boolean definitions, a
  // timestamped FIFO for pipeline position, and a bitwise MISR.
  function automatic logic [63:0] ref_f(input int id, input logic [63:0] xv);
    int n_in, n_out;
    logic [63:0] map, res;
    logic a, b;
    n_in  = (id == 0) ? 10 : 6;
    n_out = (id == 0) ? 30 : 5;
    map   = (id == 0) ? 64'h2AAAAAAA : 64'h15;
    a = xv[0] & xv[4];
    b = xv[3] ^ xv[4] ^ (xv[1] & xv[n_in-2]) ^ (xv[2] & xv[3] & xv[n_in-1]);
    res = '0;
    for (int k = 0; k < n_out; k++) res[k] = map[k] ? b : a;
    return res;
  endfunction

  function automatic logic [63:0] misr_step(input int id, input logic [63:0] s, input logic [63:0] fv);
    int w, n_out;
    logic [63:0] poly, fold, mask, ns;
    w     = (id == 0) ? 16 : 4;
    n_out = (id == 0) ? 30 : 5;
    poly  = (id == 0) ? 64'h1021 : 64'h3;
    fold  = '0;
    for (int i = 0; i < n_out; i++) fold[i % w] = fold[i % w] ^ fv[i];
    mask = (64'd1 << w) - 64'd1;
    ns   = (s << 1) & mask;
    if (s[w-1]) ns = ns ^ poly;
    return ns ^ fold;
  endfunction

  logic [63:0] qf [2][64];
  int          qt [2][64];
  int          head [2];
  int          tail [2];
  int          adv [2];
  logic [63:0] msig [2];
  int          mcnt [2];

  task automatic model_cycle(input int id, input logic iv, input logic [63:0] xv,
                             input logic ordy, input logic clr, input logic irdy,
                             input logic ov, input logic [63:0] fv,
                             input logic [63:0] sv, input logic [63:0] cv);
    string p;
    logic ev, stl;
    int stages;
    p = (id == 0) ? "m0" : "m1";
    stages = (id == 0) ? 2 : 1;
    if (rst) begin
      check({p, "_rst_out_valid"}, 64'(ov), 64'd0);
      check({p, "_rst_f"}, fv, 64'd0);
      check({p, "_rst_sig"}, sv, 64'd0);
      check({p, "_rst_count"}, cv, 64'd0);
      check({p, "_rst_in_ready"}, 64'(irdy), 64'd1);
      head[id] = 0; tail[id] = 0; adv[id] = 0; msig[id] = '0; mcnt[id] = 0;
    end else begin
      ev = (head[id] != tail[id]) && (adv[id] == qt[id][head[id]] + stages);
      check({p, "_out_valid"}, 64'(ov), 64'(ev));
      if (ev) check({p, "_f"}, fv, qf[id][head[id]]);
      stl = ev & ~ordy;
      check({p, "_in_ready"}, 64'(irdy), 64'(!stl));
      check({p, "_sig"}, sv, msig[id]);
      check({p, "_count"}, cv, 64'(mcnt[id]));
      if (clr) begin
        msig[id] = '0;
        mcnt[id] = 0;
      end else if (ev && ordy) begin
        msig[id] = misr_step(id, msig[id], qf[id][head[id]]);
        if (mcnt[id] < 65535) mcnt[id] = mcnt[id] + 1;
      end
      if (!stl) begin
        if (ev && ordy) head[id] = (head[id] + 1) % 64;
        if (iv) begin
          qf[id][tail[id]] = ref_f(id, xv);
          qt[id][tail[id]] = adv[id];
          tail[id] = (tail[id] + 1) % 64;
        end
        adv[id] = adv[id] + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, in0.in_valid, 64'(in0.x), in0.out_ready, clr0, in0.in_ready,
                in0.out_valid, 64'(in0.f), 64'(sig0), 64'(cnt0));
    model_cycle(1, in1.in_valid, 64'(in1.x), in1.out_ready, clr1, in1.in_ready,
                in1.out_valid, 64'(in1.f), 64'(sig1), 64'(cnt1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  vec [4];
  logic [29:0] f_hold;
  int idx, guard, acc1;
  logic acc;

  initial begin
    in0.in_valid = 0; in0.x = '0; in0.out_ready = 1; clr0 = 0;
    in1.in_valid = 0; in1.x = '0; in1.out_ready = 1; clr1 = 0;
    #2;
    check("reset_out_valid", 64'(in0.out_valid), 64'd0);
    check("reset_in_ready", 64'(in0.in_ready), 64'd1);
    check("reset_f", 64'(in0.f), 64'd0);
    check("reset_sig", 64'(sig0), 64'd0);
    #10 rst = 0;
    tick();

    // A=B=1, then MISR sequence from reset
    in0.in_valid = 1; in0.x = 10'b0000010001; tick();
    in0.in_valid = 0; in0.x = '0; tick();
    check("ab_valid", 64'(in0.out_valid), 64'd1);
    check("ab_f", 64'(in0.f), 64'h3FFFFFFF);
    tick();
    check("ab_bubble", 64'(in0.out_valid), 64'd0);
    check("misr1_sig", 64'(sig0), 64'hC000);
    check("misr1_count", 64'(cnt0), 64'd1);
    in0.in_valid = 1; in0.x = '0; tick();
    in0.in_valid = 0; tick();
    check("zero_f", 64'(in0.f), 64'd0);
    tick();
    check("misr2_sig", 64'(sig0), 64'h9021);
    check("misr2_count", 64'(cnt0), 64'd2);
    in0.in_valid = 1; in0.x = 10'b0000001000; tick();
    in0.in_valid = 0; tick();
    check("x3_f", 64'(in0.f), 64'h2AAAAAAA);
    clr0 = 1; tick(); clr0 = 0;
    check("clear_sig", 64'(sig0), 64'd0);
    check("clear_count", 64'(cnt0), 64'd0);
    in0.in_valid = 1; in0.x = 10'b1100001100; tick();
    in0.in_valid = 0; tick();
    check("x2389_valid", 64'(in0.out_valid), 64'd1);
    check("x2389_f", 64'(in0.f), 64'd0);
    tick();
    check("x2389_count", 64'(cnt0), 64'd1);

    // Stall: four distinct vectors, five-cycle back-pressure
    clr0 = 1; tick(); clr0 = 0;
    vec[0] = 10'h011; vec[1] = 10'h008; vec[2] = 10'h019; vec[3] = 10'h000;
    idx = 0; guard = 0;
    while (!in0.out_valid && guard < 20) begin
      in0.in_valid = 1; in0.x = vec[idx];
      @(negedge clk); acc = in0.in_valid & in0.in_ready;
      tick(); if (acc) idx++;
      guard++;
    end
    check("stall_reach_output", 64'(guard < 20), 64'd1);
    in0.out_ready = 0; in0.x = vec[idx];
    f_hold = in0.f;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in0.in_ready), 64'd0);
      check("stall_f_stable", 64'(in0.f), 64'(f_hold));
      tick();
    end
    in0.out_ready = 1; guard = 0;
    while (idx < 4 && guard < 20) begin
      in0.in_valid = 1; in0.x = vec[idx];
      @(negedge clk); acc = in0.in_valid & in0.in_ready;
      tick(); if (acc) idx++;
      guard++;
    end
    in0.in_valid = 0;
    repeat (4) tick();
    check("stall_count", 64'(cnt0), 64'd4);

    // Reset with two vectors in flight
    in0.in_valid = 1; in0.x = 10'h011; tick();
    in0.x = 10'h019; tick();
    in0.in_valid = 0;
    #2 rst = 1;
    #1;
    check("async_out_valid", 64'(in0.out_valid), 64'd0);
    check("async_f", 64'(in0.f), 64'd0);
    check("async_sig", 64'(sig0), 64'd0);
    check("async_count", 64'(cnt0), 64'd0);
    @(posedge clk); #3 rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale", 64'(in0.out_valid), 64'd0);
    end
    in0.in_valid = 1; in0.x = 10'h011; tick();
    in0.in_valid = 0;
    check("post_rst_lat_early", 64'(in0.out_valid), 64'd0);
    tick();
    check("post_rst_lat_valid", 64'(in0.out_valid), 64'd1);
    check("post_rst_lat_f", 64'(in0.f), 64'h3FFFFFFF);

    // Small configuration: latency of one stage
    in1.in_valid = 1; in1.x = 6'b010001; tick();
    in1.in_valid = 0;
    check("sweep_lat_valid", 64'(in1.out_valid), 64'd1);
    check("sweep_lat_f", 64'(in1.f), 64'h1F);
    in1.in_valid = 1; in1.x = 6'b001000; tick();
    in1.in_valid = 0;
    check("sweep_x3_f", 64'(in1.f), 64'h15);
    clr1 = 1; tick(); clr1 = 0;

    // Randomized run on both instances
    acc1 = 0; guard = 0;
    while (acc1 < 1000 && guard < 20000) begin
      in0.in_valid  = ($urandom_range(3) != 0);
      in0.x         = 10'($urandom);
      in0.out_ready = ($urandom_range(9) < 7);
      clr0          = ($urandom_range(49) == 0);
      in1.in_valid  = ($urandom_range(3) != 0);
      in1.x         = 6'($urandom);
      in1.out_ready = ($urandom_range(9) < 7);
      @(negedge clk);
      if (in1.in_valid && in1.in_ready) acc1++;
      tick();
      guard++;
    end
    check("sweep_done", 64'(acc1 >= 1000), 64'd1);
    in0.in_valid = 0; in1.in_valid = 0; clr0 = 0;
    in0.out_ready = 1; in1.out_ready = 1;
    repeat (5) tick();
    check("sweep_count", 64'(cnt1), 64'(acc1));
    check("sweep_final_sig", 64'(sig1), msig[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ccgrcg_pipe.md
# ccgrcg_pipe

Parametrised, pipelined successor to the CCGRCG-family combinational benchmark cores. It evaluates two fixed Boolean function classes over an `N_IN`-bit input vector and fans them out to `N_OUT` outputs according to a select mask. Each input vector moves through a `STAGES`-deep valid/ready pipeline. A multiple-input signature register (MISR) and a transfer counter compact the output stream, so long random-vector runs can be checked against a golden signature. It sits between the vector source and the scoreboard/BIST collector in the benchmark harness.

## Interface
Parameters:
- `N_IN`, 10, input vector width; legal range ≥ 6.
- `N_OUT`, 30, output vector width; legal range ≥ 1.
- `STAGES`, 2, number of register stages from input to output; legal range ≥ 1.
- `MAP`, 30'h2AAAAAAA (`N_OUT` bits), per-output select: bit k = 1 → `f[k]` = B, 0 → `f[k]` = A.
- `MISR_W`, 16, signature width; legal range ≥ 2.
- `POLY`, 16'h1021 (`MISR_W` bits), MISR feedback polynomial.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: source presents `x`.
- `in_ready` out 1: pipeline accepts `x` this cycle.
- `x` in `N_IN`: input vector.
- `out_valid` out 1: `f` holds a valid result.
- `out_ready` in 1: sink accepts `f`.
- `f` out `N_OUT`: result vector.
- `sig_clear` in 1: synchronous clear of `sig` and `count`.
- `sig` out `MISR_W`: current signature.
- `count` out 16: number of output transfers, saturating.

## Operation
- Functions are evaluated combinationally on `x` at stage-1 input:
  - A = x[0] & x[4]
  - B = x[3] ^ x[4] ^ (x[1] & x[N_IN-2]) ^ (x[2] & x[3] & x[N_IN-1])
- Result vector: r[k] = MAP[k] ? B : A. Only r (`N_OUT` bits) plus a valid bit is registered per stage. `x` is not carried through the pipeline.
- Pipeline uses a global stall:
  - stall = `out_valid` & ~`out_ready`
  - `in_ready` = ~stall
  - When not stalled, every stage advances. Stage 1 loads r with valid = `in_valid`.
  - When stalled, all stages hold. No input is accepted, and `in_valid` is ignored.
- Bubbles are not collapsed: an empty stage still advances one position per cycle.
- Input transfer = `in_valid` & `in_ready`. Output transfer = `out_valid` & `out_ready`.
- `f` and `out_valid` are driven directly from the last stage.
- On each output transfer:
  - `sig` ← ({`sig`[W-2:0],0} ^ (`sig`[W-1] ? `POLY` : 0)) ^ fold(`f`).
  - fold(`f`) = XOR of `f` split into `MISR_W`-bit chunks from bit 0 upward, with the last chunk zero-padded.
  - `count` ← `count`+1, saturating at 16'hFFFF.
- `sig_clear` has priority over a same-cycle transfer: `sig` ← 0 and `count` ← 0, and that transfer is not folded in. The pipeline data transfer itself still occurs.
- `sig` and `count` hold on cycles with no transfer.

## Timing
- Reset (asynchronous assert, synchronous to `clk` on release):
  - all stage valid bits 0 and data 0
  - `out_valid`=0, `f`=0, `sig`=0, `count`=0
  - `in_ready`=1
- Reset mid-operation discards all in-flight vectors. The first input after release appears after full latency.
- Latency: input accepted at edge n, with no stalls → `out_valid`=1 with its `f` after edge n+`STAGES-1`, visible in the cycle following edge n+`STAGES-1` (i.e. `STAGES` cycles of register delay counting the accepting edge).
- Throughput: one vector per cycle while `out_ready`=1.
- Under stall, `f`/`out_valid` are stable, and `in_ready`=0 combinationally in the same cycle.
- `in_ready` depends combinationally on `out_ready`. Sources must not make `in_valid` depend on `in_ready`.
- `sig`/`count` update at the edge ending the transfer cycle and are visible the next cycle.

## Test plan
- Reset, then `x`=10'b0000010001 (x0=1, x4=1) for one cycle with `out_ready`=1 → A=1, B=1; two cycles later `out_valid`=1, `f`=30'h3FFFFFFF, then `out_valid`=0.
- `x`=10'b0000001000 (x3 only) → `f`=30'h2AAAAAAA. `x`=0 → `f`=0. `x`=10'b1100001100 (x2, x3, x8, x9) → B=1^0^0^1=0, A=0 → `f`=0.
- MISR: from reset, transfer `f`=30'h3FFFFFFF → `sig`=16'hC000, `count`=1; then transfer `f`=0 → `sig`=16'h9021, `count`=2; assert `sig_clear` together with a third transfer → `sig`=0, `count`=0.
- Stall: stream 4 distinct vectors, hold `out_ready`=0 for 5 cycles once `out_valid` rises:
  - `in_ready`=0 throughout the stall, and `f` is constant.
  - After release, the outputs appear in order with none lost or duplicated, and `count` ends at 4.
- Reset asserted with 2 vectors in flight → `out_valid`=0, `f`=0, `sig`=0, `count`=0 immediately (asynchronous); no stale vector emerges after release.
- Parameter sweep at `STAGES`=1, `N_IN`=6, `N_OUT`=5, `MAP`=5'b10101, `MISR_W`=4, `POLY`=4'h3, random 1000 vectors with random `out_ready` → compared bit-exact against a reference model including the final `sig`; latency measured as 1.
